rrf_alloc_ctrl: RTL and testbench

- Rename-register-file (RRF) entry allocator shared by the two decode slots (A = older, B = younger).
- Keeps the RRF as an in-order circular buffer: decode allocates at the tail, retire frees at the head.
- Each cycle it issues up to two destination tags and generates per-slot rename errors. Decode uses these errors to hold the Fetch/Decode FF and insert a bubble.
- Sits between the decode stage's map-enable requests and the register file's destination-allocation path.

---
 rtl/rrf_alloc_ctrl_if.sv | 25 ++
 rtl/rrf_alloc_ctrl.sv | 89 ++++++++
 tb/tb_rrf_alloc_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/rrf_alloc_ctrl_if.sv
// Decode-slot allocation bus: two map requests plus stall in, two grants/tags/errors out.
// The master is decode and the slave is the allocator; grants are combinational (zero latency).
interface rrf_alloc_ctrl_if #(
  parameter int TAG_W = 3
);
  logic             map_en_A;
  logic             map_en_B;
  logic             stall;
  logic             grant_A;
  logic             grant_B;
  logic [TAG_W-1:0] tag_A;
  logic [TAG_W-1:0] tag_B;
  logic             errorA;
  logic             errorB;

  modport master (
    output map_en_A, map_en_B, stall,
    input  grant_A, grant_B, tag_A, tag_B, errorA, errorB
  );

  modport slave (
    input  map_en_A, map_en_B, stall,
    output grant_A, grant_B, tag_A, tag_B, errorA, errorB
  );
endinterface

// File: rtl/rrf_alloc_ctrl.sv
// In-order circular RRF allocator. Grants and tags are zero-latency; state updates on the next edge.
// Stall holds allocation so the same tags are re-offered; retire and flush still apply under stall.
module rrf_alloc_ctrl #(
  parameter int RRF_DEPTH = 8,
  parameter int TAG_W     = 3
) (
  input  logic             clk,
  input  logic             rst,
  rrf_alloc_ctrl_if.slave  alloc,
  input  logic             retire_en_A,
  input  logic             retire_en_B,
  input  logic             flush,
  output logic [TAG_W:0]   free_count,
  output logic             full,
  output logic             empty,
  output logic             retire_err
);

  localparam logic [TAG_W:0] DEPTH_C = (TAG_W+1)'(RRF_DEPTH);

  logic [TAG_W-1:0] head_q;
  logic [TAG_W-1:0] tail_q;
  logic [TAG_W:0]   occ_q;
  logic             retire_err_q;

  logic [TAG_W:0]   free;
  logic [TAG_W:0]   need_b;
  logic [TAG_W:0]   nalloc;
  logic [TAG_W:0]   alloc_cnt;
  logic [TAG_W:0]   nret_req;
  logic [TAG_W:0]   nret;
  logic             over_retire;
  logic             orphan_b;
  logic             commit;
  logic [TAG_W-1:0] head_next;

  always_comb begin
    free = DEPTH_C - occ_q;
    need_b = alloc.grant_A ? (TAG_W+1)'(2) : (TAG_W+1)'(1);

    alloc.grant_A = alloc.map_en_A & (free != '0);
    alloc.errorA  = alloc.map_en_A & ~alloc.grant_A;
    // B is younger: it can never be granted past a refused A
    alloc.grant_B = alloc.map_en_B & ~alloc.errorA & (free >= need_b);
    alloc.errorB  = alloc.map_en_B & ~alloc.grant_B;

    alloc.tag_A = tail_q;
    alloc.tag_B = tail_q + TAG_W'(alloc.grant_A);
  end

  always_comb begin
    nalloc    = (TAG_W+1)'(alloc.grant_A) + (TAG_W+1)'(alloc.grant_B);
    commit    = ~alloc.stall & ~flush;
    alloc_cnt = commit ? nalloc : '0;

    nret_req    = (TAG_W+1)'(retire_en_A) + (TAG_W+1)'(retire_en_A & retire_en_B);
    orphan_b    = retire_en_B & ~retire_en_A;
    over_retire = nret_req > occ_q;
    nret        = over_retire ? occ_q : nret_req;
    head_next   = head_q + TAG_W'(nret);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q       <= '0;
      tail_q       <= '0;
      occ_q        <= '0;
      retire_err_q <= 1'b0;
    end else begin
      head_q <= head_next;
      if (orphan_b | over_retire)
        retire_err_q <= 1'b1;
      if (flush) begin
        // everything between the post-retire head and tail is discarded
        tail_q <= head_next;
        occ_q  <= '0;
      end else begin
        tail_q <= tail_q + TAG_W'(alloc_cnt);
        occ_q  <= occ_q + alloc_cnt - nret;
      end
    end
  end

  assign free_count = free;
  assign full       = (occ_q == DEPTH_C);
  assign empty      = (occ_q == '0);
  assign retire_err = retire_err_q;

endmodule

// File: tb/tb_rrf_alloc_ctrl.sv
// Bench for rrf_alloc_ctrl: directed literal scenarios, then random traffic against a tag-queue model.
module tb_rrf_alloc_ctrl;
  localparam int DEPTH = 8;
  localparam int TW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          retire_en_A, retire_en_B, flush;
  logic [TW:0]   free_count;
  logic          full, empty, retire_err;

  int checks = 0;
  int errors = 0;

  rrf_alloc_ctrl_if #(.TAG_W(TW)) bus ();

  rrf_alloc_ctrl #(.RRF_DEPTH(DEPTH), .TAG_W(TW)) dut (
    .clk         (clk),
    .rst         (rst),
    .alloc       (bus.slave),
    .retire_en_A (retire_en_A),
    .retire_en_B (retire_en_B),
    .flush       (flush),
    .free_count  (free_count),
    .full        (full),
    .empty       (empty),
    .retire_err  (retire_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the RRF is the ordered list of live tags; next_tag is where the next allocation lands.
  int q[$];
  int next_tag;
  bit m_err;

  always @(negedge clk) begin
    int occ, fr, req;
    bit ega, eea, egb, eeb;
    if (rst) begin
      q.delete();
      next_tag = 0;
      m_err = 1'b0;
    end else begin
      occ = q.size();
      fr  = DEPTH - occ;
      ega = bus.map_en_A && fr >= 1;
      eea = bus.map_en_A && !ega;
      egb = bus.map_en_B && !eea && fr >= (ega ? 2 : 1);
      eeb = bus.map_en_B && !egb;

      chk("free_count", 32'(free_count), 32'(fr));
      chk("full", 32'(full), 32'(occ == DEPTH));
      chk("empty", 32'(empty), 32'(occ == 0));
      chk("retire_err", 32'(retire_err), 32'(m_err));
      chk("grant_A", 32'(bus.grant_A), 32'(ega));
      chk("grant_B", 32'(bus.grant_B), 32'(egb));
      chk("errorA", 32'(bus.errorA), 32'(eea));
      chk("errorB", 32'(bus.errorB), 32'(eeb));
      if (ega) chk("tag_A", 32'(bus.tag_A), 32'(next_tag));
      if (egb) chk("tag_B", 32'(bus.tag_B), 32'((next_tag + (ega ? 1 : 0)) % DEPTH));

      req = retire_en_A ? (retire_en_B ? 2 : 1) : 0;
      if (retire_en_B && !retire_en_A) m_err = 1'b1;
      if (req > q.size()) begin
        m_err = 1'b1;
        req = q.size();
      end
      for (int i = 0; i < req; i++) void'(q.pop_front());

      if (flush) begin
        if (q.size() != 0) next_tag = q[0];
        q.delete();
      end else if (!bus.stall) begin
        if (ega) begin q.push_back(next_tag); next_tag = (next_tag + 1) % DEPTH; end
        if (egb) begin q.push_back(next_tag); next_tag = (next_tag + 1) % DEPTH; end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit ma, input bit mb, input bit st, input bit ra, input bit rb, input bit fl);
    bus.map_en_A = ma; bus.map_en_B = mb; bus.stall = st;
    retire_en_A = ra; retire_en_B = rb; flush = fl;
    #1;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    cyc(); cyc();
    rst = 1'b0;
  endtask

  initial begin
    do_rst();
    chk("rst free_count", 32'(free_count), 32'd8);
    chk("rst empty", 32'(empty), 32'd1);
    chk("rst full", 32'(full), 32'd0);
    chk("rst grant_A", 32'(bus.grant_A), 32'd0);
    chk("rst errorA", 32'(bus.errorA), 32'd0);
    chk("rst retire_err", 32'(retire_err), 32'd0);

    drive(1, 1, 0, 0, 0, 0);
    chk("first grant_A", 32'(bus.grant_A), 32'd1);
    chk("first grant_B", 32'(bus.grant_B), 32'd1);
    chk("first tag_A", 32'(bus.tag_A), 32'd0);
    chk("first tag_B", 32'(bus.tag_B), 32'd1);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    chk("after first free", 32'(free_count), 32'd6);

    drive(1, 1, 0, 0, 0, 0); cyc(); cyc();
    drive(1, 0, 0, 0, 0, 0); cyc();
    drive(1, 1, 0, 0, 0, 0);
    chk("occ7 free", 32'(free_count), 32'd1);
    chk("occ7 grant_A", 32'(bus.grant_A), 32'd1);
    chk("occ7 tag_A", 32'(bus.tag_A), 32'd7);
    chk("occ7 errorB", 32'(bus.errorB), 32'd1);
    cyc();
    chk("full flag", 32'(full), 32'd1);
    chk("full errorA", 32'(bus.errorA), 32'd1);
    chk("full errorB", 32'(bus.errorB), 32'd1);

    drive(1, 0, 0, 1, 0, 0);
    chk("full+retire errorA", 32'(bus.errorA), 32'd1);
    cyc();
    drive(1, 0, 0, 0, 0, 0);
    chk("post-retire free", 32'(free_count), 32'd1);
    chk("post-retire grant_A", 32'(bus.grant_A), 32'd1);
    chk("wrap tag_A", 32'(bus.tag_A), 32'd0);
    cyc();

    drive(0, 0, 0, 0, 0, 1); cyc();
    drive(1, 1, 0, 0, 0, 0); cyc(); cyc();
    drive(1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("stall tag_A", 32'(bus.tag_A), 32'd5);
      chk("stall tag_B", 32'(bus.tag_B), 32'd6);
      chk("stall free", 32'(free_count), 32'd4);
      cyc();
    end
    drive(1, 1, 0, 0, 0, 0); cyc();
    drive(1, 0, 0, 0, 0, 0);
    chk("unstall tag_A", 32'(bus.tag_A), 32'd7);
    chk("unstall free", 32'(free_count), 32'd2);

    do_rst();
    drive(1, 1, 0, 0, 0, 0); cyc();
    drive(0, 0, 0, 1, 1, 0); cyc();
    drive(1, 1, 0, 0, 0, 0); cyc(); cyc();
    drive(0, 0, 0, 0, 0, 0);
    chk("pre-flush free", 32'(free_count), 32'd4);
    drive(0, 0, 0, 1, 0, 1); cyc();
    drive(1, 0, 0, 0, 0, 0);
    chk("post-flush free", 32'(free_count), 32'd8);
    chk("post-flush empty", 32'(empty), 32'd1);
    chk("post-flush tag_A", 32'(bus.tag_A), 32'd3);

    drive(0, 0, 0, 0, 1, 0); cyc();
    drive(0, 0, 0, 0, 0, 0);
    chk("orphan B retire_err", 32'(retire_err), 32'd1);
    chk("orphan B free", 32'(free_count), 32'd8);
    do_rst();
    chk("retire_err cleared", 32'(retire_err), 32'd0);
    drive(0, 0, 0, 1, 0, 0); cyc();
    drive(0, 0, 0, 0, 0, 0); cyc(); cyc(); cyc();
    chk("empty retire sticky", 32'(retire_err), 32'd1);
    chk("empty retire free", 32'(free_count), 32'd8);

    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom % 250) == 0;
      drive(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 5) == 0,
            ($urandom % 2) == 0, ($urandom % 2) == 0, ($urandom % 40) == 0);
      cyc();
    end
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    cyc(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
